// File: rtl/pipe_adder_if.sv
// Handshake bundle for pipe_adder: operand side (in_*/x/y/sub) and result side (out_*/sum/flags).
interface pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, x, y, sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );

  modport slave (
    input  in_valid, x, y, sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/pipe_adder.sv
// Chunked ripple add/sub over STAGES registered stages; latency STAGES, one result per cycle.
// Whole pipeline freezes (in_ready low) while the output is held by out_ready low.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_adder_if.slave bus
);

  localparam int CW = WIDTH / STAGES;

  logic en;

  assign en           = !g_stg[STAGES-1].v_q || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Operand bits still waiting to be added, and low sum bits already finished.
    localparam int IN_W   = WIDTH - k * CW;
    localparam int DONE_W = (k + 1) * CW;

    logic [IN_W-1:0]   xi;
    logic [IN_W-1:0]   yi;
    logic              ci;
    logic              vi;
    logic              xs_i;
    logic              ys_i;
    logic [CW:0]       part;
    logic [DONE_W-1:0] sum_d;

    logic              v_q;
    logic              c_q;
    logic              xs_q;
    logic              ys_q;
    logic [DONE_W-1:0] sum_q;

    if (k == 0) begin : g_src
      assign xi    = bus.x;
      assign yi    = bus.sub ? ~bus.y : bus.y;
      assign ci    = bus.sub;
      assign vi    = bus.in_valid;
      assign xs_i  = bus.x[WIDTH-1];
      assign ys_i  = yi[IN_W-1];
      assign sum_d = part[CW-1:0];
    end else begin : g_src
      assign xi    = g_stg[k-1].g_ops.x_q;
      assign yi    = g_stg[k-1].g_ops.y_q;
      assign ci    = g_stg[k-1].c_q;
      assign vi    = g_stg[k-1].v_q;
      assign xs_i  = g_stg[k-1].xs_q;
      assign ys_i  = g_stg[k-1].ys_q;
      assign sum_d = {part[CW-1:0], g_stg[k-1].sum_q};
    end

    assign part = {1'b0, xi[CW-1:0]} + {1'b0, yi[CW-1:0]} + {{CW{1'b0}}, ci};

    // Bubbles advance the valid bit but leave the data registers untouched.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        xs_q  <= 1'b0;
        ys_q  <= 1'b0;
        sum_q <= '0;
      end else if (en) begin
        v_q <= vi;
        if (vi) begin
          c_q   <= part[CW];
          xs_q  <= xs_i;
          ys_q  <= ys_i;
          sum_q <= sum_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [IN_W-CW-1:0] x_q;
      logic [IN_W-CW-1:0] y_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q <= '0;
          y_q <= '0;
        end else if (en && vi) begin
          x_q <= xi[IN_W-1:CW];
          y_q <= yi[IN_W-1:CW];
        end
      end
    end
  end

  assign bus.out_valid = g_stg[STAGES-1].v_q;
  assign bus.sum       = g_stg[STAGES-1].sum_q;
  assign bus.carry     = g_stg[STAGES-1].c_q;
  assign bus.overflow  = (g_stg[STAGES-1].xs_q == g_stg[STAGES-1].ys_q) &&
                         (g_stg[STAGES-1].sum_q[WIDTH-1] != g_stg[STAGES-1].xs_q);

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=16, STAGES=4): directed vectors, stall and mid-flight reset.
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(16)) bus ();

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   pops    = 0;
  bit   lat_chk = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  // Monitor: a result transfers on the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result sum=%h carry=%b overflow=%b", bus.sum, bus.carry, bus.overflow);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", bus.sum, e.s);
        chk("carry", bus.carry, e.c);
        chk("overflow", bus.overflow, e.o);
        if (lat_chk) chk("latency", cyc - e.cyc, 4);
        pops++;
        pop_cyc.push_back(cyc);
      end
    end
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] yy;
    logic [16:0] r;
    exp_t        e;
    yy    = s ? ~b : b;
    r     = {1'b0, a} + {1'b0, yy} + {16'b0, s};
    e.s   = r[15:0];
    e.c   = r[16];
    e.o   = (a[15] == yy[15]) && (r[15] != a[15]);
    e.cyc = 0;
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [15:0] es, input logic ec, input logic eo);
    int   t;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.x        = a;
    bus.y        = b;
    bus.sub      = s;
    t            = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout x=%h y=%h got in_ready=0 want 1", a, b);
    end else begin
      e.s   = es;
      e.c   = ec;
      e.o   = eo;
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      t++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int   p0;
    exp_t m;
    logic [15:0] a;
    logic [15:0] b;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    bus.sub      = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_sum", bus.sum, 0);
    chk("reset_carry", bus.carry, 0);
    chk("reset_overflow", bus.overflow, 0);
    chk("reset_in_ready", bus.in_ready, 1);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", bus.in_ready, 1);

    // Directed arithmetic corners, back to back.
    lat_chk = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send(16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    send(16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0);
    send(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0);
    wait_drain();

    // Ten back-to-back transactions against the reference model.
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      a = 16'(i * 16'h1F3D + 16'h0100);
      b = 16'(16'hABCD ^ (i * 16'h0731));
      m = model(a, b, i[0]);
      send(a, b, i[0], m.s, m.c, m.o);
    end
    wait_drain();
    chk("burst_count", pops - p0, 10);
    if (pops - p0 == 10) chk("burst_consecutive", pop_cyc[p0+9] - pop_cyc[p0], 9);

    // Fill the pipeline with the consumer stalled, hold five cycles, then release.
    lat_chk       = 1'b0;
    bus.out_ready = 1'b0;
    p0            = pops;
    send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    send(16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0);
    send(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0);
    fork
      send(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    join_none
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_sum", bus.sum, 16'h5555);
      chk("stall_carry", bus.carry, 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();
    chk("stall_count", pops - p0, 5);

    // Reset with three transactions in flight.
    lat_chk = 1'b1;
    send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    send(16'h4444, 16'h1111, 1'b1, 16'h3333, 1'b1, 1'b0);
    send(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", bus.out_valid, 0);
    chk("midreset_sum", bus.sum, 0);
    chk("midreset_carry", bus.carry, 0);
    chk("midreset_in_ready", bus.in_ready, 1);
    exp_q.delete();
    p0 = pops;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_reset_idle", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    wait_drain();
    chk("post_reset_count", pops - p0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
